// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command queue and issue sequencer for a registered 4-bit ALU
//
// Purpose: accepts ALU commands into a 4-entry FIFO, tags each with a wrapping
// 2-bit id, issues one command per cycle to the downstream ALU and re-aligns
// the ALU's registered result with the issued opcode/tag on the output side.
//
// Ports:
//   clk, reset (async, active low)
//   in_valid/in_ready, in_opcode[1:0], in_a[3:0], in_b[3:0]  command input
//   hold   - pauses issue while high
//   flush  - discards queued and in-flight commands
//   alu_opcode[1:0], alu_a[3:0], alu_b[3:0], alu_reset        to the ALU
//   alu_c[4:0]                                               registered ALU result
//   out_valid, out_result[4:0], out_opcode[1:0], out_tag[1:0] completed result
//   fifo_count[2:0], busy, mismatch                           status
//
// Optional feature: define ALU_SEQ_CHECK_EN to build the result checker that
// drives a sticky mismatch flag; otherwise mismatch is tied low.

module alu_cmd_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_opcode,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic       hold,
  input  logic       flush,
  output logic [1:0] alu_opcode,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_reset,
  input  logic [4:0] alu_c,
  output logic       out_valid,
  output logic [4:0] out_result,
  output logic [1:0] out_opcode,
  output logic [1:0] out_tag,
  output logic [2:0] fifo_count,
  output logic       busy,
  output logic       mismatch
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t      r_state;
  logic [11:0] r_mem [4];      // {tag, opcode, a, b}
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_count;
  logic [1:0]  r_tag;
  logic [1:0]  r_alu_opcode;
  logic [3:0]  r_alu_a;
  logic [3:0]  r_alu_b;
  logic        r_iss_valid;
  logic [1:0]  r_iss_tag;
  logic        r_out_valid;
  logic [1:0]  r_out_opcode;
  logic [1:0]  r_out_tag;

  logic        w_push;
  logic        w_pop;
  logic [11:0] w_head;

  assign in_ready = (r_count < 3'd4) && (r_state != S_FLUSH);
  // flush beats a same-cycle push and pop
  assign w_push   = in_valid && in_ready && !flush;
  assign w_pop    = (r_count != 3'd0) && !hold && (r_state == S_RUN) && !flush;
  assign w_head   = r_mem[r_rd_ptr];

  // Storage needs no reset: emptiness is carried entirely by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_tag, in_opcode, in_a, in_b};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= 2'd0;
      r_rd_ptr     <= 2'd0;
      r_count      <= 3'd0;
      r_tag        <= 2'd0;
      r_alu_opcode <= 2'd0;
      r_alu_a      <= 4'd0;
      r_alu_b      <= 4'd0;
      r_iss_valid  <= 1'b0;
      r_iss_tag    <= 2'd0;
      r_out_valid  <= 1'b0;
      r_out_opcode <= 2'd0;
      r_out_tag    <= 2'd0;
    end else if (flush) begin
      // tag counter deliberately survives a flush
      r_state     <= S_FLUSH;
      r_wr_ptr    <= 2'd0;
      r_rd_ptr    <= 2'd0;
      r_count     <= 3'd0;
      r_iss_valid <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:  if (w_push) r_state <= S_RUN;
        S_RUN:   if ((r_count == 3'd0) && !r_iss_valid && !w_push) r_state <= S_IDLE;
        S_FLUSH: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
        r_tag    <= r_tag + 2'd1;
      end

      // alu_* hold their last values between issues
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + 2'd1;
        r_iss_tag    <= w_head[11:10];
        r_alu_opcode <= w_head[9:8];
        r_alu_a      <= w_head[7:4];
        r_alu_b      <= w_head[3:0];
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase

      r_iss_valid <= w_pop;
      // ALU registers the issued fields on the same edge, so alu_c and this
      // stage line up with out_valid.
      r_out_valid <= r_iss_valid;
      if (r_iss_valid) begin
        r_out_opcode <= r_alu_opcode;
        r_out_tag    <= r_iss_tag;
      end
    end
  end

  assign alu_opcode = r_alu_opcode;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_reset  = !reset || (r_state == S_FLUSH);
  assign out_valid  = r_out_valid;
  assign out_result = alu_c;
  assign out_opcode = r_out_opcode;
  assign out_tag    = r_out_tag;
  assign fifo_count = r_count;
  assign busy       = (r_state != S_IDLE);

`ifdef ALU_SEQ_CHECK_EN
  logic [4:0] w_exp;
  logic [4:0] r_exp;
  logic       r_mismatch;

  // Expected result of the currently issued fields; captured when the
  // issue moves to the output stage so it stays aligned with alu_c.
  always_comb begin
    w_exp = 5'd0;
    case (r_alu_opcode)
      2'b00:   w_exp = {r_alu_a[3], r_alu_a} + {r_alu_b[3], r_alu_b};
      2'b01:   w_exp = {r_alu_a[3], r_alu_a} - {r_alu_b[3], r_alu_b};
      2'b10:   w_exp = ~{r_alu_a[3], r_alu_a};
      default: w_exp = {4'b0000, |r_alu_b};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_exp      <= 5'd0;
      r_mismatch <= 1'b0;
    end else begin
      if (r_iss_valid) r_exp <= w_exp;
      if (r_out_valid && (alu_c != r_exp)) r_mismatch <= 1'b1;
    end
  end

  assign mismatch = r_mismatch;
`else
  assign mismatch = 1'b0;
`endif

endmodule
